// File: rtl/calc_scan_if.sv
// Bus between the calculator core and the multiplexed 7-segment display stage.
// master: the core side. It drives the five active-low digit patterns and the
//         opcode echo, and observes the display outputs.
// slave : the display scanner. It consumes the patterns and drives seg_out
//         (shared segment bus), an (active-low anodes) and frame_tick.
interface calc_scan_if;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic [6:0] seg_r;
    logic [1:0] lop;
    logic [6:0] seg_out;
    logic [5:0] an;
    logic       frame_tick;

    modport master (
        output seg_a, seg_b, seg_tens, seg_ones, seg_r, lop,
        input  seg_out, an, frame_tick
    );

    modport slave (
        input  seg_a, seg_b, seg_tens, seg_ones, seg_r, lop,
        output seg_out, an, frame_tick
    );
endinterface

// File: rtl/calc_scan_display.sv
// Time-multiplexed 6-digit common-anode display driver for the calculator core.
// It snapshots the core's patterns once per frame, so a frame never shows a mix
// of old and new values. It scans six slots (a, op glyph, b, tens, ones, rem)
// with blanking at the start of each slot, so two digits never glow together.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - calc_scan_if.slave: seg_a/seg_b/seg_tens/seg_ones/seg_r/lop in;
//          seg_out (active-low), an (active-low, an[5] leftmost), frame_tick out
// Parameters:
//   SCAN_DIV  - clock cycles per digit slot (>= BLANK_CYC+2)
//   BLANK_CYC - all-anodes-off cycles at the start of each slot (>= 1)
// Optional feature: define CALC_SCAN_LZB_EN to blank the tens digit (slot 3)
// for the whole slot when its snapshot is the '0' pattern.
module calc_scan_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    calc_scan_if.slave  bus
);
    localparam int unsigned CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [2:0]       IDX_LAST  = 3'd5;
    localparam logic [6:0]       SEG_OFF   = 7'b1111111;
    localparam logic [6:0]       SEG_ZERO  = 7'b1000000;
    localparam logic [5:0]       AN_OFF    = 6'b111111;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    phase_t           state_q, state_d;
    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic             fresh;
    logic [6:0]       snap_a, snap_b, snap_tens, snap_ones, snap_r;
    logic [1:0]       snap_op;

    logic             div_wrap_c;
    logic             capture_c;
    logic             lzb_c;
    logic [6:0]       glyph_c;
    logic [6:0]       slot_pat_c;
    logic [6:0]       seg_d;
    logic [5:0]       an_d;

    assign div_wrap_c = (div_cnt == CNT_LAST);
    // Capture on the frame boundary, and once right after reset so frame 0 is live.
    assign capture_c  = fresh || (div_wrap_c && (idx == IDX_LAST));

    // Operator glyph from the snapshotted opcode.
    always_comb begin
        glyph_c = 7'b0001000;
        case (snap_op)
            2'b00:   glyph_c = 7'b0001000;
            2'b01:   glyph_c = 7'b0111111;
            2'b10:   glyph_c = 7'b0001001;
            default: glyph_c = 7'b0100001;
        endcase
    end

    // Pattern for the current slot.
    always_comb begin
        slot_pat_c = SEG_OFF;
        case (idx)
            3'd0:    slot_pat_c = snap_a;
            3'd1:    slot_pat_c = glyph_c;
            3'd2:    slot_pat_c = snap_b;
            3'd3:    slot_pat_c = snap_tens;
            3'd4:    slot_pat_c = snap_ones;
            3'd5:    slot_pat_c = snap_r;
            default: slot_pat_c = SEG_OFF;
        endcase
    end

`ifdef CALC_SCAN_LZB_EN
    assign lzb_c = (idx == 3'd3) && (snap_tens == SEG_ZERO);
`else
    assign lzb_c = 1'b0;
`endif

    // Phase FSM: BLANK for the first BLANK_CYC cycles of a slot, then DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PH_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        case (state_q)
            PH_BLANK: begin
                if (div_cnt == BLANK_END) begin
                    state_d = PH_DRIVE;
                end
            end
            PH_DRIVE: begin
                if (!lzb_c) begin
                    an_d  = ~(6'b100000 >> idx);
                    seg_d = slot_pat_c;
                end
                if (div_wrap_c) begin
                    state_d = PH_BLANK;
                end
            end
            default: state_d = PH_BLANK;
        endcase
    end

    // Slot counters, snapshot registers and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt        <= '0;
            idx            <= '0;
            fresh          <= 1'b1;
            snap_a         <= SEG_OFF;
            snap_b         <= SEG_OFF;
            snap_tens      <= SEG_OFF;
            snap_ones      <= SEG_OFF;
            snap_r         <= SEG_OFF;
            snap_op        <= 2'b00;
            bus.seg_out    <= SEG_OFF;
            bus.an         <= AN_OFF;
            bus.frame_tick <= 1'b0;
        end else begin
            fresh          <= 1'b0;
            bus.frame_tick <= capture_c;
            bus.seg_out    <= seg_d;
            bus.an         <= an_d;
            if (div_wrap_c) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
            if (capture_c) begin
                snap_a    <= bus.seg_a;
                snap_b    <= bus.seg_b;
                snap_tens <= bus.seg_tens;
                snap_ones <= bus.seg_ones;
                snap_r    <= bus.seg_r;
                snap_op   <= bus.lop;
            end
        end
    end
endmodule

// File: tb/tb_calc_scan_display.sv
// Randomized self-checking bench for calc_scan_display (SCAN_DIV=8, BLANK_CYC=2).
// The reference model works from the elapsed clock count since reset release.
// It derives the slot and phase with plain division, and it holds the frame
// contents latched at each frame boundary.
module tb_calc_scan_display;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = 6 * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    calc_scan_if bus ();

    calc_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // posedges since reset release

    logic [6:0] m_pat [5];   // a, b, tens, ones, r as shown this frame
    logic [1:0] m_op;
    logic [6:0] glyph [4] = '{7'b0001000, 7'b0111111, 7'b0001001, 7'b0100001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at k=%0d", tag, got, exp, k);
        end
    endtask

    function automatic logic [6:0] rand_pat();
        int r;
        r = int'($urandom_range(0, 5));
        if (r == 0) return 7'b1111111;
        if (r == 1) return 7'b1000000;
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic randomize_one();
        case ($urandom_range(0, 5))
            0: bus.seg_a    = rand_pat();
            1: bus.seg_b    = rand_pat();
            2: bus.seg_tens = rand_pat();
            3: bus.seg_ones = rand_pat();
            4: bus.seg_r    = rand_pat();
            default: bus.lop = 2'($urandom_range(0, 3));
        endcase
    endtask

    // Expected registered outputs after edge kk, from the frame contents at that time.
    task automatic model_out(input int kk, output logic [6:0] es, output logic [5:0] ea);
        int p, slot, ph;
        es = 7'b1111111;
        ea = 6'b111111;
        if (kk > 0) begin
            p    = kk - 1;
            slot = (p / SD) % 6;
            ph   = p % SD;
            if (ph >= BC) begin
                ea = ~(6'b100000 >> slot);
                case (slot)
                    0: es = m_pat[0];
                    1: es = glyph[m_op];
                    2: es = m_pat[1];
                    3: es = m_pat[2];
                    4: es = m_pat[3];
                    default: es = m_pat[4];
                endcase
`ifdef CALC_SCAN_LZB_EN
                if (slot == 3 && m_pat[2] == 7'b1000000) begin
                    es = 7'b1111111;
                    ea = 6'b111111;
                end
`endif
            end
        end
    endtask

    // One clock: predict, update the frame model on capture edges, check at negedge.
    task automatic step(input bit mutate);
        logic [6:0] es;
        logic [5:0] ea;
        logic       et;
        @(posedge clk);
        k++;
        model_out(k, es, ea);
        et = (k == 1) || (k % FRAME == 0);
        if (et) begin
            m_pat[0] = bus.seg_a;
            m_pat[1] = bus.seg_b;
            m_pat[2] = bus.seg_tens;
            m_pat[3] = bus.seg_ones;
            m_pat[4] = bus.seg_r;
            m_op     = bus.lop;
        end
        @(negedge clk);
        check("seg_out", 32'(bus.seg_out), 32'(es));
        check("an", 32'(bus.an), 32'(ea));
        check("frame_tick", 32'(bus.frame_tick), 32'(et));
        check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
        if (mutate && $urandom_range(0, 7) == 0) randomize_one();
    endtask

    task automatic run(input int n, input bit mutate);
        for (int i = 0; i < n; i++) step(mutate);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(bus.seg_out), 32'h7F);
        check({tag, "_an"}, 32'(bus.an), 32'h3F);
        check({tag, "_tick"}, 32'(bus.frame_tick), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.seg_a    = 7'b1111001;
        bus.seg_b    = 7'b0100100;
        bus.seg_tens = 7'b1000000;
        bus.seg_ones = 7'b0110000;
        bus.seg_r    = 7'b1111111;
        bus.lop      = 2'b00;
        for (int i = 0; i < 5; i++) m_pat[i] = 7'b1111111;
        m_op = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        release_reset();

        // Directed frame plus tearing: change seg_ones while slot 2 is on screen.
        run(2 * SD + 3, 1'b0);
        bus.seg_ones = 7'b0011001;
        run(FRAME + FRAME - (2 * SD + 3), 1'b0);

        // Opcode glyphs across four frames.
        for (int f = 0; f < 4; f++) begin
            bus.lop = 2'(f);
            run(FRAME, 1'b0);
        end

        // Randomized inputs changing at arbitrary times.
        run(20 * FRAME, 1'b1);

        // Asynchronous reset in the middle of a DRIVE phase.
        run(SD + 4, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held_rst");
        bus.seg_tens = 7'b1000000;
        release_reset();
        run(2 * FRAME, 1'b0);

        // Tens '0' pattern kept for extra frames, then random again.
        run(4 * FRAME, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
